// File: rtl/regfile_scoreboard_pkg.sv
// regfile_scoreboard_pkg: GPR constants shared by ID, WB and the register file
package regfile_scoreboard_pkg;
  localparam int GPR_ADDR_W = 5;
  localparam int NUM_GPR = 32;
  localparam logic [GPR_ADDR_W-1:0] GPR_ZERO = 5'd0;
  typedef logic [GPR_ADDR_W-1:0] gpr_addr_t;
  function automatic logic is_gpr_write(input logic en, input gpr_addr_t a);
    return en && a != GPR_ZERO;
  endfunction
endpackage

// File: rtl/regfile_scoreboard_counter.sv
// sb_counter: saturating pending-write counter for one GPR
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf,
  output logic             unf
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // flag the increments/decrements the counter has to refuse
  always_comb begin
    ovf = inc && !dec && cnt == CNT_MAX;
    unf = dec && !inc && cnt == '0;
  end
  // simultaneous inc and dec cancel; refused steps hold the count
  always_ff @(posedge clk)
    cnt <= reset ? '0 :
           (inc && !dec && !ovf) ? cnt + 1'b1 :
           (dec && !inc && !unf) ? cnt - 1'b1 : cnt;
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2R1W GPR file with WB bypass and pending-write hazard scoreboard
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  re1,
  input  logic                  re2,
  input  logic [GPR_ADDR_W-1:0] raddr1,
  input  logic [GPR_ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0]     rdata1,
  output logic [DATA_W-1:0]     rdata2,
  output logic                  hazard,
  input  logic                  issue_valid,
  input  logic                  issue_we,
  input  logic [GPR_ADDR_W-1:0] issue_dest,
  input  logic                  rf_we,
  input  logic [GPR_ADDR_W-1:0] rf_waddr,
  input  logic [DATA_W-1:0]     rf_wdata,
  output logic                  sb_overflow,
  output logic                  sb_underflow
);
  logic [DATA_W-1:0] regs [1:NUM_GPR-1];
  logic [CNT_W-1:0] cnt [1:NUM_GPR-1];
  logic [NUM_GPR-1:0] inc, dec;
  logic [NUM_GPR-1:1] ovf, unf;
  logic [CNT_W-1:0] pend1, pend2;
  // per-register issue/retire strobes; r0 never tracked
  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 1; r < NUM_GPR; r++) begin
      inc[r] = issue_valid && issue_we && issue_dest == gpr_addr_t'(r);
      dec[r] = is_gpr_write(rf_we, rf_waddr) && rf_waddr == gpr_addr_t'(r);
    end
  end
  for (genvar g = 1; g < NUM_GPR; g++) begin : g_sb
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk(clk),
      .reset(reset),
      .inc(inc[g]),
      .dec(dec[g]),
      .cnt(cnt[g]),
      .ovf(ovf[g]),
      .unf(unf[g])
    );
  end
  // register array write; r0 writes dropped
  always_ff @(posedge clk)
    if (reset) for (int r = 1; r < NUM_GPR; r++) regs[r] <= '0;
    else if (is_gpr_write(rf_we, rf_waddr)) regs[rf_waddr] <= rf_wdata;
  // reads with WB write-through; a retiring write discounts its own pending entry
  always_comb begin
    rdata1 = raddr1 == GPR_ZERO ? '0 : (rf_we && rf_waddr == raddr1) ? rf_wdata : regs[raddr1];
    rdata2 = raddr2 == GPR_ZERO ? '0 : (rf_we && rf_waddr == raddr2) ? rf_wdata : regs[raddr2];
    pend1 = (raddr1 == GPR_ZERO ? '0 : cnt[raddr1]) - CNT_W'(dec[raddr1]);
    pend2 = (raddr2 == GPR_ZERO ? '0 : cnt[raddr2]) - CNT_W'(dec[raddr2]);
    hazard = (re1 && raddr1 != GPR_ZERO && pend1 != '0) ||
             (re2 && raddr2 != GPR_ZERO && pend2 != '0);
  end
  // sticky error flags, cleared only by reset
  always_ff @(posedge clk) begin
    sb_overflow <= reset ? 1'b0 : sb_overflow | (|ovf);
    sb_underflow <= reset ? 1'b0 : sb_underflow | (|unf);
  end
endmodule
